vpu_alu_minmax_reduce: RTL

//  Parametrised, pipelined MIN/MAX ALU with streaming reduction.
//  - Compares up to SRC_CNT source operands per lane and folds the result across all beats of a packet.
//  - Result is one MIN or MAX per lane; signed or unsigned compare, selected per packet.
//  - Sits between the VPU source ports and VPU_DST_PORT; valid/ready on both sides.
//  - Successor of the single-beat 3-operand signed MAX unit.

---
 rtl/vpu_alu_minmax_reduce_pkg.sv | 31 +++
 rtl/vpu_alu_minmax_reduce_if.sv | 34 +++
 rtl/vpu_minmax_cmp.sv | 29 ++
 rtl/vpu_alu_minmax_reduce.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/vpu_alu_minmax_reduce_pkg.sv
// Shared types and constants for the MIN/MAX reduction ALU.
// Mode encoding: bit0 selects MAX, bit1 selects signed compare.
package vpu_alu_minmax_reduce_pkg;

    localparam int OPERAND_WIDTH   = 32;
    localparam int SRAM_R_PORT_CNT = 3;
    localparam int MINMAX_LATENCY  = 2;

    typedef enum logic [1:0] {
        MIN_U = 2'd0,
        MAX_U = 2'd1,
        MIN_S = 2'd2,
        MAX_S = 2'd3
    } minmax_mode_t;

    // Neutral start value for a fold in the given mode
    function automatic logic [OPERAND_WIDTH-1:0] minmax_identity(
        input minmax_mode_t mode
    );
        logic [OPERAND_WIDTH-1:0] r;
        r = '1;
        case (mode)
            MAX_S:   r = {1'b1, {(OPERAND_WIDTH-1){1'b0}}};
            MAX_U:   r = '0;
            MIN_S:   r = {1'b0, {(OPERAND_WIDTH-1){1'b1}}};
            default: r = '1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vpu_alu_minmax_reduce_if.sv
// Source-side beat stream and destination-side result stream.
// master drives beats and consumes results; slave is the ALU.
interface vpu_alu_minmax_reduce_if
    import vpu_alu_minmax_reduce_pkg::*;
#(
    parameter int OPERAND_WIDTH = vpu_alu_minmax_reduce_pkg::OPERAND_WIDTH,
    parameter int SRC_CNT       = SRAM_R_PORT_CNT,
    parameter int LANE_CNT      = 4,
    parameter int CNT_W         = 8
) ();

    logic                                         in_valid;
    logic                                         in_ready;
    logic                                         in_last;
    logic [1:0]                                   in_mode;
    logic [SRC_CNT-1:0]                           op_valid;
    logic [SRC_CNT-1:0][LANE_CNT-1:0][OPERAND_WIDTH-1:0] op_data;
    logic                                         out_valid;
    logic                                         out_ready;
    logic [LANE_CNT-1:0][OPERAND_WIDTH-1:0]       out_data;
    logic                                         out_empty;
    logic [CNT_W-1:0]                             out_beats;

    modport master (
        output in_valid, in_last, in_mode, op_valid, op_data, out_ready,
        input  in_ready, out_valid, out_data, out_empty, out_beats
    );

    modport slave (
        input  in_valid, in_last, in_mode, op_valid, op_data, out_ready,
        output in_ready, out_valid, out_data, out_empty, out_beats
    );

endinterface

// File: rtl/vpu_minmax_cmp.sv
// Combinational compare-select; ties keep a.
// Used for the per-beat source fold and the accumulate step.
module vpu_minmax_cmp
    import vpu_alu_minmax_reduce_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  minmax_mode_t mode,
    output logic [W-1:0] sel
);

    logic b_gt;
    logic b_lt;

    // Pick b only when it strictly beats a in the requested direction
    always_comb begin
        b_gt = 1'b0;
        if (mode[1]) begin
            b_gt = $signed(b) > $signed(a);
        end else begin
            b_gt = b > a;
        end
        b_lt = !b_gt && (b != a);
        sel  = mode[0] ? (b_gt ? b : a) : (b_lt ? b : a);
    end

endmodule

// File: rtl/vpu_alu_minmax_reduce.sv
// Pipelined MIN/MAX ALU folding all sources and beats of a packet
// into one result per lane. Stage 1 folds sources, stage 2 accumulates.
module vpu_alu_minmax_reduce
    import vpu_alu_minmax_reduce_pkg::*;
#(
    parameter int OPERAND_WIDTH = vpu_alu_minmax_reduce_pkg::OPERAND_WIDTH,
    parameter int SRC_CNT       = SRAM_R_PORT_CNT,
    parameter int LANE_CNT      = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst_n,
    vpu_alu_minmax_reduce_if.slave io
);

    localparam int W = OPERAND_WIDTH;

    typedef logic [W-1:0] elem_t;
    typedef logic [LANE_CNT-1:0][W-1:0] vec_t;

    function automatic elem_t ident(input minmax_mode_t m);
        return elem_t'(minmax_identity(m));
    endfunction

    logic         adv;
    logic         accept;
    logic         pkt_start;
    minmax_mode_t cur_mode;
    minmax_mode_t beat_mode;

    assign adv         = !io.out_valid || io.out_ready;
    assign io.in_ready = adv;
    assign accept      = io.in_valid && adv;
    assign beat_mode   = pkt_start ? minmax_mode_t'(io.in_mode) : cur_mode;

    elem_t chain   [LANE_CNT][SRC_CNT+1];
    elem_t src_sel [LANE_CNT][SRC_CNT];
    vec_t  beat_val;

    for (genvar l = 0; l < LANE_CNT; l++) begin : g_lane
        assign chain[l][0] = ident(beat_mode);
        for (genvar s = 0; s < SRC_CNT; s++) begin : g_src
            vpu_minmax_cmp #(.W(W)) u_src (
                .a    (chain[l][s]),
                .b    (io.op_data[s][l]),
                .mode (beat_mode),
                .sel  (src_sel[l][s])
            );
            assign chain[l][s+1] = io.op_valid[s] ? src_sel[l][s]
                                                  : chain[l][s];
        end
        assign beat_val[l] = chain[l][SRC_CNT];
    end

    logic         s1_valid;
    logic         s1_last;
    logic         s1_any;
    minmax_mode_t s1_mode;
    vec_t         s1_val;

    // Stage 1: register the source-folded beat and track packet mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_any    <= 1'b0;
            s1_mode   <= MAX_S;
            s1_val    <= '0;
            pkt_start <= 1'b1;
            cur_mode  <= MAX_S;
        end else if (adv) begin
            s1_valid <= io.in_valid;
            if (accept) begin
                s1_last   <= io.in_last;
                s1_any    <= |io.op_valid;
                s1_mode   <= beat_mode;
                s1_val    <= beat_val;
                pkt_start <= io.in_last;
                cur_mode  <= beat_mode;
            end
        end
    end

    vec_t             acc;
    vec_t             acc_eff;
    vec_t             acc_sel;
    vec_t             acc_new;
    logic             s2_first;
    logic             any_seen;
    logic             any_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    for (genvar l = 0; l < LANE_CNT; l++) begin : g_acc
        assign acc_eff[l] = s2_first ? ident(s1_mode) : acc[l];
        vpu_minmax_cmp #(.W(W)) u_acc (
            .a    (acc_eff[l]),
            .b    (s1_val[l]),
            .mode (s1_mode),
            .sel  (acc_sel[l])
        );
        assign acc_new[l] = s1_any ? acc_sel[l] : acc_eff[l];
    end

    assign any_next = any_seen || s1_any;
    assign cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;

    // Stage 2: accumulate beats, publish and restart on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= {LANE_CNT{ident(MAX_S)}};
            s2_first     <= 1'b1;
            any_seen     <= 1'b0;
            cnt          <= '0;
            io.out_valid <= 1'b0;
            io.out_data  <= '0;
            io.out_empty <= 1'b0;
            io.out_beats <= '0;
        end else begin
            if (io.out_valid && io.out_ready) begin
                io.out_valid <= 1'b0;
            end
            if (adv && s1_valid) begin
                if (s1_last) begin
                    io.out_valid <= 1'b1;
                    io.out_data  <= any_next ? acc_new : '0;
                    io.out_empty <= !any_next;
                    io.out_beats <= cnt_next;
                    acc          <= {LANE_CNT{ident(MAX_S)}};
                    s2_first     <= 1'b1;
                    any_seen     <= 1'b0;
                    cnt          <= '0;
                end else begin
                    acc      <= acc_new;
                    s2_first <= 1'b0;
                    any_seen <= any_next;
                    cnt      <= cnt_next;
                end
            end
        end
    end

endmodule
